// File: rtl/seg_execute_alu_mdu_pkg.sv
// Shared definitions for the EX-stage ALU / multiply-divide unit.
//   - ALU op codes (also consumed by the ALU-control decoder)
//   - MDU FSM state encoding
//   - is_mdu_op(): true for the iterative MULT/MULTU/DIV/DIVU group
package seg_execute_alu_mdu_pkg;

    localparam logic [4:0] OpAnd   = 5'b00000;
    localparam logic [4:0] OpOr    = 5'b00001;
    localparam logic [4:0] OpAdd   = 5'b00010;
    localparam logic [4:0] OpSub   = 5'b00110;
    localparam logic [4:0] OpSlt   = 5'b00111;
    localparam logic [4:0] OpSltu  = 5'b01000;
    localparam logic [4:0] OpSll   = 5'b01001;
    localparam logic [4:0] OpSrl   = 5'b01010;
    localparam logic [4:0] OpSra   = 5'b01011;
    localparam logic [4:0] OpNor   = 5'b01100;
    localparam logic [4:0] OpXor   = 5'b01101;
    localparam logic [4:0] OpLui   = 5'b01110;
    localparam logic [4:0] OpMult  = 5'b10000;
    localparam logic [4:0] OpMultu = 5'b10001;
    localparam logic [4:0] OpDiv   = 5'b10010;
    localparam logic [4:0] OpDivu  = 5'b10011;
    localparam logic [4:0] OpMfhi  = 5'b10100;
    localparam logic [4:0] OpMflo  = 5'b10101;
    localparam logic [4:0] OpMthi  = 5'b10110;
    localparam logic [4:0] OpMtlo  = 5'b10111;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mdu_state_e;

    // MULT/MULTU/DIV/DIVU share the 100xx prefix; bit 1 = divide, bit 0 = unsigned.
    function automatic logic is_mdu_op(input logic [4:0] op);
        return op[4:2] == 3'b100;
    endfunction

endpackage

// File: rtl/seg_execute_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiplier, restoring divider, both on
// operand magnitudes with the sign fixed up in the DONE state.
// Ports:
//   clk, reset (sync, active-low), flush (abort in-flight op)
//   start         accept an iterative op this cycle (only while ready)
//   kind[1:0]     bit 1 = divide, bit 0 = unsigned
//   a, b          operands, latched on start
//   wr_hi/wr_lo   MTHI/MTLO write of wr_data (wins over a same-edge MDU write)
//   ready         not busy iterating
//   done          in DONE state: result/div_zero valid, HI/LO written at the edge
//   result        new LO value; div_zero flag; hi, lo architectural registers
module seg_execute_mdu
    import seg_execute_alu_mdu_pkg::*;
#(
    parameter int unsigned LEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           start,
    input  logic [1:0]     kind,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    input  logic           wr_hi,
    input  logic           wr_lo,
    input  logic [LEN-1:0] wr_data,
    output logic           ready,
    output logic           done,
    output logic [LEN-1:0] result,
    output logic           div_zero,
    output logic [LEN-1:0] hi,
    output logic [LEN-1:0] lo
);
    localparam int unsigned CntW = $clog2(LEN);

    mdu_state_e     state_q;
    logic [CntW-1:0] cnt_q;
    logic [LEN-1:0] acc_q;      // product upper half / partial remainder
    logic [LEN-1:0] low_q;      // multiplier->product lower half / dividend->quotient
    logic [LEN-1:0] mag_b_q;    // multiplicand or divisor magnitude
    logic [LEN-1:0] a_q;        // raw dividend, returned in HI on divide-by-zero
    logic           is_div_q, neg_a_q, neg_b_q, dz_q;

    logic           neg_a, neg_b;
    logic [LEN:0]   mul_sum, div_shift, div_diff;
    logic [2*LEN-1:0] prod, prod_fin;
    logic [LEN-1:0] quot, rem, fin_hi, fin_lo;

    assign neg_a = ~kind[0] & a[LEN-1];
    assign neg_b = ~kind[0] & b[LEN-1];

    assign mul_sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, mag_b_q} : '0);
    assign div_shift = {acc_q, low_q[LEN-1]};
    assign div_diff  = div_shift - {1'b0, mag_b_q};

    assign prod     = {acc_q, low_q};
    assign prod_fin = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quot     = (neg_a_q ^ neg_b_q) ? -low_q : low_q;
    assign rem      = neg_a_q ? -acc_q : acc_q;   // remainder follows the dividend

    always_comb begin
        fin_hi = prod_fin[2*LEN-1:LEN];
        fin_lo = prod_fin[LEN-1:0];
        if (is_div_q) begin
            fin_hi = dz_q ? a_q : rem;
            fin_lo = dz_q ? '1 : quot;
        end
    end

    assign ready    = (state_q != StBusy);
    assign done     = (state_q == StDone);
    assign result   = fin_lo;
    assign div_zero = dz_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            mag_b_q  <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            if (flush) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: if (start) state_q <= StBusy;
                    StBusy: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntW'(LEN - 1)) state_q <= StDone;
                        if (is_div_q) begin
                            // Restoring step: keep the difference only if it did not borrow.
                            if (!div_diff[LEN]) begin
                                acc_q <= div_diff[LEN-1:0];
                                low_q <= {low_q[LEN-2:0], 1'b1};
                            end else begin
                                acc_q <= div_shift[LEN-1:0];
                                low_q <= {low_q[LEN-2:0], 1'b0};
                            end
                        end else begin
                            acc_q <= mul_sum[LEN:1];
                            low_q <= {mul_sum[0], low_q[LEN-1:1]};
                        end
                    end
                    StDone: begin
                        hi      <= fin_hi;
                        lo      <= fin_lo;
                        state_q <= start ? StBusy : StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
                if (start) begin
                    cnt_q    <= '0;
                    acc_q    <= '0;
                    low_q    <= neg_a ? -a : a;
                    mag_b_q  <= neg_b ? -b : b;
                    a_q      <= a;
                    is_div_q <= kind[1];
                    neg_a_q  <= neg_a;
                    neg_b_q  <= neg_b;
                    dz_q     <= kind[1] & (b == '0);
                end
            end
            // A move-to issued in DONE is younger than the finishing op, so it wins.
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
        end
    end

endmodule

// File: rtl/seg_execute_alu_mdu.sv
// EX-stage ALU with iterative multiply/divide and HI/LO, valid/ready handshake.
// Ports:
//   i_clk, i_reset (sync, active-low), i_flush (abort mul/div in flight)
//   i_valid/o_ready   accept = i_valid & o_ready (never while flushing)
//   i_ALUctl, i_data_a, i_data_b, i_shamt   op and operands
//   o_valid           1-cycle pulse qualifying o_result/o_zero/o_overflow/o_div_zero
module seg_execute_alu_mdu
    import seg_execute_alu_mdu_pkg::*;
#(
    parameter int unsigned LEN       = 32,
    parameter int unsigned NB_ALUCTL = 5,
    parameter int unsigned NB_SHAMT  = $clog2(LEN)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NB_ALUCTL-1:0] i_ALUctl,
    input  logic [LEN-1:0]       i_data_a,
    input  logic [LEN-1:0]       i_data_b,
    input  logic [NB_SHAMT-1:0]  i_shamt,
    output logic                 o_valid,
    output logic [LEN-1:0]       o_result,
    output logic                 o_zero,
    output logic                 o_overflow,
    output logic                 o_div_zero
);
    logic [4:0]     op;
    logic [LEN-1:0] sum, diff, alu_res, hi, lo, mdu_result;
    logic [LEN-1:0] pend_result_q;
    logic           alu_ovf, accept, take_single, mdu_start, mdu_fin;
    logic           mdu_ready, mdu_done, mdu_div_zero, wr_hi, wr_lo;
    logic           pend_valid_q, pend_ovf_q;

    assign op   = i_ALUctl[4:0];
    assign sum  = i_data_a + i_data_b;
    assign diff = i_data_a - i_data_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OpAnd:  alu_res = i_data_a & i_data_b;
            OpOr:   alu_res = i_data_a | i_data_b;
            OpNor:  alu_res = ~(i_data_a | i_data_b);
            OpXor:  alu_res = i_data_a ^ i_data_b;
            OpAdd: begin
                alu_res = sum;
                alu_ovf = (i_data_a[LEN-1] == i_data_b[LEN-1]) && (sum[LEN-1] != i_data_a[LEN-1]);
            end
            OpSub: begin
                alu_res = diff;
                alu_ovf = (i_data_a[LEN-1] != i_data_b[LEN-1]) && (diff[LEN-1] != i_data_a[LEN-1]);
            end
            OpSlt:  alu_res = {{(LEN-1){1'b0}}, $signed(i_data_a) < $signed(i_data_b)};
            OpSltu: alu_res = {{(LEN-1){1'b0}}, i_data_a < i_data_b};
            OpSll:  alu_res = i_data_a << i_shamt;
            OpSrl:  alu_res = i_data_a >> i_shamt;
            OpSra:  alu_res = $signed(i_data_a) >>> i_shamt;
            OpLui:  alu_res = i_data_b << (LEN / 2);
            OpMfhi: alu_res = hi;
            OpMflo: alu_res = lo;
            OpMthi, OpMtlo: alu_res = i_data_a;
            default: ;
        endcase
    end

    assign o_ready     = mdu_ready;
    assign accept      = i_valid & o_ready & ~i_flush;
    assign mdu_start   = accept & is_mdu_op(op);
    assign take_single = accept & ~is_mdu_op(op);
    assign wr_hi       = accept & (op == OpMthi);
    assign wr_lo       = accept & (op == OpMtlo);
    assign mdu_fin     = mdu_done & ~i_flush;

    seg_execute_mdu #(.LEN(LEN)) u_mdu (
        .clk      (i_clk),
        .reset    (i_reset),
        .flush    (i_flush),
        .start    (mdu_start),
        .kind     (op[1:0]),
        .a        (i_data_a),
        .b        (i_data_b),
        .wr_hi    (wr_hi),
        .wr_lo    (wr_lo),
        .wr_data  (i_data_a),
        .ready    (mdu_ready),
        .done     (mdu_done),
        .result   (mdu_result),
        .div_zero (mdu_div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    // A single-cycle op accepted in DONE collides with the MDU result, so it is
    // parked one cycle; later back-to-back ops stay one cycle behind until a bubble.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_valid       <= 1'b0;
            o_result      <= '0;
            o_zero        <= 1'b0;
            o_overflow    <= 1'b0;
            o_div_zero    <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_result_q <= '0;
            pend_ovf_q    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (mdu_fin) begin
                o_valid    <= 1'b1;
                o_result   <= mdu_result;
                o_zero     <= (mdu_result == '0);
                o_overflow <= 1'b0;
                o_div_zero <= mdu_div_zero;
            end else if (pend_valid_q) begin
                o_valid    <= 1'b1;
                o_result   <= pend_result_q;
                o_zero     <= (pend_result_q == '0);
                o_overflow <= pend_ovf_q;
                o_div_zero <= 1'b0;
            end else if (take_single) begin
                o_valid    <= 1'b1;
                o_result   <= alu_res;
                o_zero     <= (alu_res == '0);
                o_overflow <= alu_ovf;
                o_div_zero <= 1'b0;
            end
            if (mdu_fin || pend_valid_q) begin
                pend_valid_q <= take_single;
                if (take_single) begin
                    pend_result_q <= alu_res;
                    pend_ovf_q    <= alu_ovf;
                end
            end
        end
    end

endmodule
